rate_scheduler: RTL and testbench

//  Owns one programmable square-wave divider (outClock derived from inClock) and shares it

---
 rtl/rate_scheduler_pkg.sv | 16 +
 rtl/rate_div_iter.sv | 61 ++++++
 rtl/rate_scheduler.sv | 142 ++++++++++++++
 tb/tb_rate_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rate_scheduler_pkg.sv
// Shared types and constants for the rate scheduler slice.
package rate_sched_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    DIV,
    WAIT_EDGE,
    COMMIT,
    REJECT
  } state_t;

endpackage

// File: rtl/rate_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, done pulses on the last step.
module rate_div_iter
  import rate_sched_pkg::*;
#(
  parameter int unsigned RATE_W = 20
) (
  input  logic              inClock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  dividend,
  input  logic [RATE_W-1:0] divisor,
  output logic [CNT_W-1:0]  quotient,
  output logic              done
);

  localparam int unsigned STEP_W = $clog2(DIV_CYCLES);

  logic [STEP_W-1:0] step;
  logic              running;
  logic [RATE_W-1:0] rem;
  logic [RATE_W-1:0] divReg;
  logic [CNT_W-1:0]  quo;
  logic [RATE_W:0]   remShift;
  logic [RATE_W:0]   remSub;

  // A set top bit of remSub means the trial subtraction went negative.
  always_comb begin
    remShift = {rem, quo[CNT_W-1]};
    remSub   = remShift - {1'b0, divReg};
  end

  always_ff @(posedge inClock or negedge reset) begin
    if (!reset) begin
      step    <= '0;
      running <= 1'b0;
      rem     <= '0;
      divReg  <= '0;
      quo     <= '0;
    end else if (start) begin
      step    <= '0;
      running <= 1'b1;
      rem     <= '0;
      divReg  <= divisor;
      quo     <= dividend;
    end else if (running) begin
      if (!remSub[RATE_W]) begin
        rem <= remSub[RATE_W-1:0];
        quo <= {quo[CNT_W-2:0], 1'b1};
      end else begin
        rem <= remShift[RATE_W-1:0];
        quo <= {quo[CNT_W-2:0], 1'b0};
      end
      step <= step + STEP_W'(1);
      if (step == STEP_W'(DIV_CYCLES - 1)) running <= 1'b0;
    end
  end

  assign done     = running && (step == STEP_W'(DIV_CYCLES - 1));
  assign quotient = quo;

endmodule

// File: rtl/rate_scheduler.sv
// Shared programmable square-wave divider with round-robin rate-change arbitration.
// Optional RATE_SCHED_CLAMP_EN: clamp over-range rates to MAX_HZ instead of rejecting them.
module rate_scheduler
  import rate_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RATE_W     = 20,
  parameter int unsigned DEFAULT_HZ = 100,
  parameter int unsigned MAX_HZ     = 1000000
) (
  input  logic                        inClock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*RATE_W-1:0]   rateHz,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          nack,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy,
  output logic                        outClock,
  output logic                        tick
);

  localparam int unsigned       IDX_W      = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]  RESET_HALF = CNT_W'(CLK_HZ / (2 * DEFAULT_HZ));
  localparam logic [CNT_W-1:0]  DIVIDEND   = CNT_W'(CLK_HZ / 2);
  localparam logic [RATE_W-1:0] MAX_RATE   = RATE_W'(MAX_HZ);

  state_t            state, nextState;
  logic [IDX_W-1:0]  rrPtr, grant, pick, nextPtr;
  logic              pickValid;
  logic [RATE_W-1:0] pickRate, divRate;
  logic              rejectRate;
  logic [CNT_W-1:0]  counter, halfPeriod, quotient;
  logic              phaseEnd, fallEdge;
  logic              divStart, divDone;

  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pickValid && req[(32'(rrPtr) + i) % NUM_REQ]) begin
        pickValid = 1'b1;
        pick      = IDX_W'((32'(rrPtr) + i) % NUM_REQ);
      end
    end
  end

  assign pickRate = rateHz[32'(pick)*RATE_W +: RATE_W];

`ifdef RATE_SCHED_CLAMP_EN
  assign rejectRate = (pickRate == '0);
  assign divRate    = (pickRate > MAX_RATE) ? MAX_RATE : pickRate;
`else
  assign rejectRate = (pickRate == '0) || (pickRate > MAX_RATE);
  assign divRate    = pickRate;
`endif

  assign nextPtr = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

  rate_div_iter #(
    .RATE_W (RATE_W)
  ) u_div (
    .inClock  (inClock),
    .reset    (reset),
    .start    (divStart),
    .dividend (DIVIDEND),
    .divisor  (divRate),
    .quotient (quotient),
    .done     (divDone)
  );

  always_comb begin
    nextState = state;
    ack       = '0;
    nack      = '0;
    busy      = (state != IDLE);
    divStart  = 1'b0;
    case (state)
      IDLE:      if (|req) nextState = ARB;
      ARB: begin
        if (!pickValid)     nextState = IDLE;
        else if (rejectRate) nextState = REJECT;
        else begin
          nextState = DIV;
          divStart  = 1'b1;
        end
      end
      DIV:       if (divDone) nextState = WAIT_EDGE;
      WAIT_EDGE: if (fallEdge) nextState = COMMIT;
      COMMIT: begin
        ack[grant] = 1'b1;
        nextState  = IDLE;
      end
      REJECT: begin
        nack[grant] = 1'b1;
        nextState   = IDLE;
      end
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge inClock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rrPtr <= '0;
      grant <= '0;
      owner <= '0;
    end else begin
      state <= nextState;
      if (state == ARB) grant <= pick;
      if (state == COMMIT) begin
        owner <= grant;
        rrPtr <= nextPtr;
      end
      if (state == REJECT) rrPtr <= nextPtr;
    end
  end

  assign phaseEnd = (counter == halfPeriod - CNT_W'(1));
  assign fallEdge = phaseEnd && outClock;

  // New half-period lands on the falling toggle, so the old period always completes.
  always_ff @(posedge inClock or negedge reset) begin
    if (!reset) begin
      counter    <= '0;
      halfPeriod <= RESET_HALF;
      outClock   <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick <= phaseEnd && !outClock;
      if (phaseEnd) begin
        counter  <= '0;
        outClock <= ~outClock;
      end else begin
        counter <= counter + CNT_W'(1);
      end
      if (state == WAIT_EDGE && fallEdge) halfPeriod <= quotient;
    end
  end

endmodule

// File: tb/tb_rate_scheduler.sv
// Scoreboard bench for rate_scheduler (CLK_HZ=1000, DEFAULT_HZ=100, MAX_HZ=250, NUM_REQ=4).
module tb_rate_scheduler;

  localparam int unsigned RW = 20;

  logic            inClock = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [4*RW-1:0] rateHz;
  logic [3:0]      ack, nack;
  logic [1:0]      owner;
  logic            busy, outClock, tick;

  always #5 inClock = ~inClock;

  rate_scheduler #(
    .CLK_HZ     (1000),
    .NUM_REQ    (4),
    .RATE_W     (RW),
    .DEFAULT_HZ (100),
    .MAX_HZ     (250)
  ) dut (
    .inClock  (inClock),
    .reset    (reset),
    .req      (req),
    .rateHz   (rateHz),
    .ack      (ack),
    .nack     (nack),
    .owner    (owner),
    .busy     (busy),
    .outClock (outClock),
    .tick     (tick)
  );

  typedef struct {
    logic        isAck;
    int unsigned idx;
    int unsigned half;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned curHalf = 5;
  int unsigned phaseLen = 0;
  logic        prevClk = 1'b0;
  logic        fellNow;

  function automatic void check(string name, longint actual, longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic void pushExp(logic isAck, int unsigned idx, int unsigned half);
    exp_t e;
    e.isAck = isAck;
    e.idx   = idx;
    e.half  = half;
    expQ.push_back(e);
  endfunction

  task automatic setRate(input int unsigned idx, input int unsigned hz);
    rateHz[idx*RW +: RW] = RW'(hz);
  endtask

  // Waits for n ack/nack pulses, releasing each requester once it is answered.
  task automatic waitResp(input int n, output int firstLat);
    int got = 0;
    int cyc = 0;
    firstLat = -1;
    while (got < n && cyc < 300) begin
      @(negedge inClock);
      cyc++;
      if ((ack | nack) != 4'b0) begin
        if (got == 0) firstLat = cyc;
        got++;
        req = req & ~(ack | nack);
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", got, n);
    end
  endtask

  // Monitor: phase lengths, tick alignment and the ack/nack scoreboard.
  always @(negedge inClock) begin
    exp_t e;
    if (!reset) begin
      phaseLen = 0;
      prevClk  = 1'b0;
      curHalf  = 5;
    end else begin
      phaseLen++;
      fellNow = 1'b0;
      if (outClock !== prevClk) begin
        check("phase_len", longint'(phaseLen), longint'(curHalf));
        if (outClock) check("tick_on_rise", longint'(tick), 1);
        fellNow  = !outClock;
        phaseLen = 0;
        prevClk  = outClock;
      end else if (tick !== 1'b0) begin
        check("tick_stray", longint'(tick), 0);
      end
      if ((ack | nack) != 4'b0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: ack=%b nack=%b expected none", ack, nack);
        end else begin
          e = expQ.pop_front();
          check("ack_vec",  longint'(ack),  e.isAck ? longint'(1) << e.idx : 0);
          check("nack_vec", longint'(nack), e.isAck ? 0 : longint'(1) << e.idx);
          if (e.isAck) begin
            check("ack_after_fall", longint'(fellNow), 1);
            curHalf = e.half;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic early;
    reset  = 1'b0;
    req    = '0;
    rateHz = '0;
    repeat (3) @(negedge inClock);
    check("rst_outClock", longint'(outClock), 0);
    check("rst_tick",     longint'(tick), 0);
    check("rst_ack",      longint'(ack), 0);
    check("rst_nack",     longint'(nack), 0);
    check("rst_busy",     longint'(busy), 0);
    check("rst_owner",    longint'(owner), 0);
    #1 reset = 1'b1;

    // 1: default rate, period 10
    repeat (40) @(negedge inClock);

    // 2: requester 1 asks for 50 Hz -> half-period 10
    setRate(1, 50);
    pushExp(1'b1, 1, 10);
    req[1] = 1'b1;
    waitResp(1, lat);
    @(negedge inClock);
    check("owner_s2", longint'(owner), 1);
    repeat (60) @(negedge inClock);

    // 3: simultaneous 0,2,3 with rrPtr=2 -> order 2,3,0
    setRate(2, 250);
    setRate(3, 125);
    setRate(0, 100);
    pushExp(1'b1, 2, 2);
    pushExp(1'b1, 3, 4);
    pushExp(1'b1, 0, 5);
    req = 4'b1101;
    waitResp(3, lat);
    @(negedge inClock);
    check("owner_s3", longint'(owner), 0);
    repeat (30) @(negedge inClock);

    // 4: zero rate rejected; over-range rate rejected or clamped
    setRate(3, 0);
    pushExp(1'b0, 3, 0);
    req[3] = 1'b1;
    waitResp(1, lat);
    check("nack_latency", longint'(lat), 2);
    repeat (30) @(negedge inClock);
    setRate(3, 300);
`ifdef RATE_SCHED_CLAMP_EN
    pushExp(1'b1, 3, 2);
`else
    pushExp(1'b0, 3, 0);
`endif
    req[3] = 1'b1;
    waitResp(1, lat);
    repeat (30) @(negedge inClock);

    // 5: reset during DIV loses the request
    setRate(1, 50);
    req[1] = 1'b1;
    repeat (10) @(negedge inClock);
    check("busy_in_div", longint'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy",     longint'(busy), 0);
    check("midrst_outClock", longint'(outClock), 0);
    check("midrst_ack",      longint'(ack | nack), 0);
    check("midrst_owner",    longint'(owner), 0);
    req = '0;
    expQ.delete();
    @(negedge inClock);
    #1 reset = 1'b1;
    repeat (60) @(negedge inClock);

    // 6: requester 2 drops its request while waiting for the edge
    setRate(2, 125);
    pushExp(1'b1, 2, 4);
    req[2] = 1'b1;
    early = 1'b0;
    repeat (34) begin
      @(negedge inClock);
      if ((ack | nack) != 4'b0) early = 1'b1;
    end
    check("early_resp", longint'(early), 0);
    req[2] = 1'b0;
    waitResp(1, lat);
    @(negedge inClock);
    check("owner_s6", longint'(owner), 2);
    repeat (40) @(negedge inClock);

    check("queue_empty", longint'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
